// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer/arbiter.
package mult_arb_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_DONE} state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  // One spare bit over the iteration range keeps the counter at 4 bits for WIDTH=8.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NREQ requesters with a registered last-winner pointer.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] last_q, last_d;

  // Search starts one past the last winner, so a repeat requester loses to anyone else.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j   = 0;
    jj  = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j  = (int'(last_q) + 1 + i) % NREQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (update && any) last_d = idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IW'(NREQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Sequencer + round-robin arbiter sharing one shift-add multiplier datapath.
// Define MULT_ARB_SIGNED_EN for two's-complement multiply (final iteration subtracts).
module mult_arbiter import mult_arb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     M,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  sel,
  output logic                     load_op,
  output logic                     add,
  output logic                     sub,
  output logic                     shift,
  output logic [NREQ-1:0]          done,
  output logic                     busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int IW = $clog2(NREQ);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            load_op_q, load_op_d, shift_q, shift_d, busy_q, busy_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (Clk),
    .rst    (reset),
    .req    (req),
    .update (state_q == S_IDLE),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Control outputs are computed one state ahead so they leave flops directly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    load_op_d = 1'b0;
    shift_d   = 1'b0;
    done_d    = '0;
    case (state_q)
      S_IDLE: if (pick_any) begin
        state_d   = S_LOAD;
        gnt_d     = pick_gnt;
        sel_d     = pick_idx;
        load_op_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_ADD;
        shift_d = 1'b1;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // shift flop must be high while in SHIFT, i.e. the cycle after ADD
    shift_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      load_op_q <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      load_op_q <= load_op_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign load_op = load_op_q;
  assign shift   = shift_q;
  assign done    = done_q;
  assign busy    = busy_q;

  logic in_add, last_it;
  assign in_add  = (state_q == S_ADD);
  assign last_it = (cnt_q == LAST);

`ifdef MULT_ARB_SIGNED_EN
  assign add = in_add & M & ~last_it;
  assign sub = in_add & M & last_it;
`else
  assign add = in_add & M;
  assign sub = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural A/X/B datapath attached.
module tb_mult_arbiter;

`ifdef MULT_ARB_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       M;
  logic [1:0] gnt, done;
  logic [0:0] sel;
  logic       load_op, add, sub, shift, busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic       use_dp = 1'b0;
  logic       m_drv  = 1'b0;
  logic [7:0] op_s = '0, op_b = '0, dp_a, dp_b;
  logic       dp_x;

  assign M = use_dp ? dp_b[0] : m_drv;

  always #5 Clk = ~Clk;

  mult_arbiter #(.WIDTH(8), .NREQ(2)) dut (
    .Clk(Clk), .reset(reset), .req(req), .M(M), .gnt(gnt), .sel(sel),
    .load_op(load_op), .add(add), .sub(sub), .shift(shift), .done(done), .busy(busy)
  );

  // Shift-add datapath: X is the 9th sum bit (carry unsigned, sign when signed).
  always @(posedge Clk) begin
    if (load_op) begin
      dp_a <= '0; dp_x <= 1'b0; dp_b <= op_b;
    end else if (add) begin
      {dp_x, dp_a} <= {SGN & dp_a[7], dp_a} + {SGN & op_s[7], op_s};
    end else if (sub) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} - {op_s[7], op_s};
    end else if (shift) begin
      dp_x <= SGN ? dp_x : 1'b0;
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end

  task automatic apply_reset();
    @(posedge Clk); #1;
    req = 2'b00; m_drv = 1'b0; reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
  endtask

  // Current cycle is cycle 0 (IDLE); returns in cycle 19 (IDLE again).
  task automatic run_job(input string tag, input logic [1:0] rq, input logic [7:0] mpat,
                         input int win, input bit drop5, output int shifts);
    logic [1:0] eg, ed;
    logic el, es, ea, eu, eb, in_a;
    int k;
    shifts = 0;
    req = rq;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s c0 busy: got %b want 0", tag, busy); end
    for (int c = 1; c <= 19; c++) begin
      @(posedge Clk); #1;
      if (drop5 && c == 5) req = 2'b00;
      k    = (c >= 2) ? (c - 2) / 2 : 0;
      in_a = (c >= 2) && (c <= 17) && (c % 2 == 0);
      m_drv = in_a ? mpat[k] : 1'b0;
      el = (c == 1);
      es = (c >= 3) && (c <= 17) && (c % 2 == 1);
      ea = in_a && mpat[k] && !(SGN && k == 7);
      eu = in_a && mpat[k] && SGN && (k == 7);
      eb = (c <= 18);
      eg = (c <= 18) ? 2'(1 << win) : 2'b00;
      ed = (c == 18) ? 2'(1 << win) : 2'b00;
      #1;
      if (shift === 1'b1) shifts++;
      n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL %s c%0d gnt: got %b want %b", tag, c, gnt, eg); end
      n_chk++; if (done !== ed) begin n_fail++; $display("FAIL %s c%0d done: got %b want %b", tag, c, done, ed); end
      n_chk++; if (busy !== eb) begin n_fail++; $display("FAIL %s c%0d busy: got %b want %b", tag, c, busy, eb); end
      n_chk++; if (load_op !== el) begin n_fail++; $display("FAIL %s c%0d load_op: got %b want %b", tag, c, load_op, el); end
      n_chk++; if (shift !== es) begin n_fail++; $display("FAIL %s c%0d shift: got %b want %b", tag, c, shift, es); end
      n_chk++; if (add !== ea) begin n_fail++; $display("FAIL %s c%0d add: got %b want %b", tag, c, add, ea); end
      n_chk++; if (sub !== eu) begin n_fail++; $display("FAIL %s c%0d sub: got %b want %b", tag, c, sub, eu); end
      if (c <= 18) begin
        n_chk++; if (sel !== 1'(win)) begin n_fail++; $display("FAIL %s c%0d sel: got %b want %0d", tag, c, sel, win); end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL %s gnt: got %b want 00", tag, gnt); end
    n_chk++; if (sel !== 1'b0) begin n_fail++; $display("FAIL %s sel: got %b want 0", tag, sel); end
    n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL %s done: got %b want 00", tag, done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    n_chk++; if ({load_op, add, sub, shift} !== 4'b0000) begin
      n_fail++; $display("FAIL %s ctl{load,add,sub,shift}: got %b want 0000", tag, {load_op, add, sub, shift});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    m_drv = 1'b1;
    #1;
    check_idle_outputs("reset");
    m_drv = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single_job();
    int s;
    apply_reset();
    run_job("single", 2'b01, 8'b1000_0001, 0, 1'b0, s);
    req = 2'b00;
    n_chk++; if (s != 8) begin n_fail++; $display("FAIL single shift_count: got %0d want 8", s); end
  endtask

  task automatic test_m_zero();
    int s;
    run_job("mzero", 2'b01, 8'h00, 0, 1'b0, s);
    req = 2'b00;
    n_chk++; if (s != 8) begin n_fail++; $display("FAIL mzero shift_count: got %0d want 8", s); end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset();
    run_job("b2b0", 2'b11, 8'h5A, 0, 1'b0, s);
    run_job("b2b1", 2'b11, 8'hA5, 1, 1'b0, s);
    run_job("b2b2", 2'b11, 8'hFF, 0, 1'b0, s);
    run_job("b2b3", 2'b11, 8'h80, 1, 1'b0, s);
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    int s;
    apply_reset();
    req = 2'b01; m_drv = 1'b1;
    repeat (9) begin @(posedge Clk); #1; end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid pre busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    check_idle_outputs("rstmid");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      n_chk++; if ({done, busy} !== 3'b000) begin
        n_fail++; $display("FAIL rstmid hold%0d done/busy: got %b want 000", i, {done, busy});
      end
    end
    reset = 1'b0; m_drv = 1'b0;
    run_job("rstprio", 2'b11, 8'h00, 0, 1'b0, s);
    req = 2'b00;
    apply_reset();
    run_job("rst10", 2'b10, 8'h03, 1, 1'b0, s);
    req = 2'b00;
  endtask

  task automatic test_drop_req();
    int s;
    run_job("drop", 2'b10, 8'h11, 1, 1'b1, s);
    req = 2'b00;
  endtask

  task automatic test_integration();
    int s;
    apply_reset();
    use_dp = 1'b1;
`ifdef MULT_ARB_SIGNED_EN
    op_s = 8'd7; op_b = 8'hFD;
    run_job("mul_7x-3", 2'b01, 8'hFD, 0, 1'b0, s);
    n_chk++; if ({dp_a, dp_b} !== 16'hFFEB) begin n_fail++; $display("FAIL mul_7x-3 product: got %h want ffeb", {dp_a, dp_b}); end
    op_s = 8'h80; op_b = 8'h80;
    run_job("mul_-128x-128", 2'b01, 8'h80, 0, 1'b0, s);
    n_chk++; if ({dp_a, dp_b} !== 16'h4000) begin n_fail++; $display("FAIL mul_-128x-128 product: got %h want 4000", {dp_a, dp_b}); end
`else
    op_s = 8'hFF; op_b = 8'hFF;
    run_job("mul_255x255", 2'b01, 8'hFF, 0, 1'b0, s);
    n_chk++; if ({dp_a, dp_b} !== 16'hFE01) begin n_fail++; $display("FAIL mul_255x255 product: got %h want fe01", {dp_a, dp_b}); end
    op_s = 8'd13; op_b = 8'd11;
    run_job("mul_13x11", 2'b01, 8'd11, 0, 1'b0, s);
    n_chk++; if ({dp_a, dp_b} !== 16'h008F) begin n_fail++; $display("FAIL mul_13x11 product: got %h want 008f", {dp_a, dp_b}); end
`endif
    req = 2'b00;
    use_dp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_m_zero();
    test_back_to_back();
    test_reset_mid();
    test_drop_req();
    test_integration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
